slice_scan_scheduler: RTL and testbench
=======================================

Name: slice_scan_scheduler

Overview:
- Sequences one scan: per slice, settle, fire one HC-SR04 measurement, capture the distance, then command a one-slice stepper advance.
- Repeats for NUM_SLICES slices, then finishes.
- Provides the start/pause/slice-count/finish status consumed by the seven-segment status display. It also provides captured samples for downstream storage.
- Sits between the top-level key debouncers, the HC-SR04 ranging unit and the stepper driver.

Parameters:
- NUM_SLICES, 16, slices per scan (1..16); slice_num_o saturates here.
- SETTLE_CYCLES, 25000, cycles spent in SETTLE before each trigger (>=1).
- MEAS_TIMEOUT, 1900000, max cycles in WAIT_MEAS before forcing a timeout sample (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle pulse; starts a scan from IDLE or DONE.
- pause_i  in  1  one-cycle pulse; toggles pause.
- meas_trig_o  out  1  one-cycle pulse requesting one measurement.
- meas_done_i  in  1  one-cycle pulse; distance_i valid this cycle.
- distance_i  in  32  ranging result; bits [15:0] are used.
- step_req_o  out  1  stepper advance request, level.
- step_ack_i  in  1  stepper done, one-cycle pulse.
- state_o  out  2  0 IDLE, 1 GO, 2 PAUSE, 3 DONE.
- slice_num_o  out  5  completed slices, 0..NUM_SLICES.
- finish_o  out  1  high while in DONE.
- sample_valid_o  out  1  one-cycle pulse per captured slice.
- sample_slice_o  out  5  index of captured slice, 0-based.
- sample_dist_o  out  16  captured distance, or 16'hFFFF on timeout.
- timeout_o  out  1  sticky; any slice of the current scan timed out.

Behaviour:
- Reset (rst sampled high at clk edge): FSM goes to IDLE. All outputs are 0, pause_pending=0 and counters=0. Reset overrides everything, including mid-measurement and mid-step.
- Internal states: IDLE, SETTLE, TRIG, WAIT_MEAS, STEP, PAUSED, DONE.
- state_o mapping: IDLE->0; SETTLE/TRIG/WAIT_MEAS/STEP->1; PAUSED->2; DONE->3.
- IDLE / DONE:
  - start_i -> SETTLE next cycle.
  - On that transition, clear slice_num_o, timeout_o and pause_pending, and load the settle counter.
  - pause_i is ignored in IDLE and DONE. With start_i and pause_i together, start wins and pause is dropped.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles.
  - On the last cycle: if pause_pending -> PAUSED (clear pause_pending); else -> TRIG.
- TRIG: meas_trig_o=1 for exactly this one cycle -> WAIT_MEAS. The timeout counter is cleared.
- WAIT_MEAS:
  - On meas_done_i: capture distance_i[15:0].
  - Otherwise, after MEAS_TIMEOUT cycles in WAIT_MEAS: capture 16'hFFFF and set timeout_o.
  - On capture, the next cycle shows sample_valid_o=1, sample_slice_o = old slice_num_o, and slice_num_o incremented. That cycle the FSM is in STEP, or in DONE if the new count == NUM_SLICES.
  - meas_done_i on the same cycle as the timeout: the real distance wins and timeout_o is not set.
  - meas_done_i outside WAIT_MEAS is ignored.
- STEP:
  - step_req_o=1 in every STEP cycle.
  - A step_ack_i seen in STEP -> SETTLE next cycle (counter reloaded), and step_req_o drops that cycle.
  - step_ack_i outside STEP is ignored.
  - No step is issued after the final slice.
- Pause:
  - pause_i in SETTLE/TRIG/WAIT_MEAS/STEP toggles pause_pending.
  - An in-flight measurement or step always completes. Pause takes effect only at the end of the next SETTLE, so no trigger is fired while paused.
  - PAUSED: pause_i -> SETTLE with full SETTLE_CYCLES reload. The frozen counters are preserved.
- DONE: finish_o=1, state_o=3, slice_num_o holds NUM_SLICES until rst or start_i.
- Widths: slice_num_o never exceeds NUM_SLICES. Counters are sized for their parameter with no wrap.

Test Plan (NUM_SLICES=3, SETTLE_CYCLES=4, MEAS_TIMEOUT=20; ranging model answers 10 cycles after trigger with distance_i=slice*100+7; stepper acks 3 cycles after req rises):
- Normal scan: start_i at cycle 0 -> meas_trig_o at cycle 5; sample_valid_o with slice 0 / dist 7, then slice 1 / 107, then slice 2 / 207; exactly 2 step_req_o episodes; then finish_o=1, state_o=3, slice_num_o=3, timeout_o=0.
- Timeout: ranging model silent on slice 1 -> sample_dist_o=16'hFFFF exactly 20 cycles after that WAIT_MEAS entry; timeout_o=1; the scan still finishes with slice_num_o=3.
- Pause during WAIT_MEAS of slice 0 -> the slice-0 sample is still produced and the step completes; after the next 4-cycle settle, state_o=2 with no trigger; pause_i again -> trigger 5 cycles later; the scan completes.
- Double pause (pause_i twice within one SETTLE) -> pause cancelled, state_o never 2, timing identical to the normal scan.
- rst asserted in STEP with step_req_o=1 -> next cycle all outputs 0 and state_o=0; a stray step_ack_i is ignored; a new start_i runs the full scan.
- Restart from DONE: start_i -> slice_num_o=0, timeout_o=0, finish_o=0 next cycle. start_i together with pause_i in IDLE -> scan runs without pausing.

Source files
------------

// File: rtl/slice_scan_scheduler.sv
// slice_scan_scheduler: sequences settle, trigger, capture and step for each slice of one scan
module slice_scan_scheduler #(
  parameter int NUM_SLICES    = 16,
  parameter int SETTLE_CYCLES = 25000,
  parameter int MEAS_TIMEOUT  = 1900000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        pause_i,
  output logic        meas_trig_o,
  input  logic        meas_done_i,
  input  logic [31:0] distance_i,
  output logic        step_req_o,
  input  logic        step_ack_i,
  output logic [1:0]  state_o,
  output logic [4:0]  slice_num_o,
  output logic        finish_o,
  output logic        sample_valid_o,
  output logic [4:0]  sample_slice_o,
  output logic [15:0] sample_dist_o,
  output logic        timeout_o
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(MEAS_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SETTLE, TRIG, WAIT_MEAS, STEP, PAUSED, DONE} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [4:0] slice_q, slice_d, sslice_q, sslice_d;
  logic [15:0] dist_q, dist_d;
  logic pend_q, pend_d, timeout_q, timeout_d, valid_q, valid_d;
  logic active, capture;
  logic unused_dist;
  assign unused_dist = ^distance_i[31:16];
  always_comb begin
    active = state_q == SETTLE || state_q == TRIG || state_q == WAIT_MEAS || state_q == STEP;
    capture = state_q == WAIT_MEAS && (meas_done_i || tmo_q == TW'(MEAS_TIMEOUT - 1));
    state_d = state_q;
    settle_d = settle_q;
    tmo_d = tmo_q;
    slice_d = slice_q;
    sslice_d = sslice_q;
    dist_d = dist_q;
    pend_d = pend_q ^ (active && pause_i);
    timeout_d = timeout_q;
    valid_d = capture;
    case (state_q)
      IDLE, DONE: if (start_i) begin
        state_d = SETTLE;
        settle_d = SW'(SETTLE_CYCLES - 1);
        slice_d = '0;
        timeout_d = 1'b0;
        pend_d = 1'b0;
      end
      SETTLE: if (settle_q == '0) begin
        state_d = pend_d ? PAUSED : TRIG;
        pend_d = 1'b0;
      end else settle_d = settle_q - 1'b1;
      TRIG: begin
        state_d = WAIT_MEAS;
        tmo_d = '0;
      end
      WAIT_MEAS: if (capture) begin
        slice_d = slice_q + 5'd1;
        sslice_d = slice_q;
        dist_d = meas_done_i ? distance_i[15:0] : 16'hFFFF;
        timeout_d = timeout_q | ~meas_done_i;
        state_d = (slice_q + 5'd1 == 5'(NUM_SLICES)) ? DONE : STEP;
      end else tmo_d = tmo_q + 1'b1;
      STEP: if (step_ack_i) begin
        state_d = SETTLE;
        settle_d = SW'(SETTLE_CYCLES - 1);
      end
      PAUSED: if (pause_i) begin
        state_d = SETTLE;
        settle_d = SW'(SETTLE_CYCLES - 1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      settle_q <= '0;
      tmo_q <= '0;
      slice_q <= '0;
      sslice_q <= '0;
      dist_q <= '0;
      pend_q <= 1'b0;
      timeout_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      settle_q <= settle_d;
      tmo_q <= tmo_d;
      slice_q <= slice_d;
      sslice_q <= sslice_d;
      dist_q <= dist_d;
      pend_q <= pend_d;
      timeout_q <= timeout_d;
      valid_q <= valid_d;
    end
  end
  assign meas_trig_o = state_q == TRIG;
  assign step_req_o = state_q == STEP;
  assign finish_o = state_q == DONE;
  assign state_o = state_q == IDLE ? 2'd0 : state_q == PAUSED ? 2'd2 : state_q == DONE ? 2'd3 : 2'd1;
  assign slice_num_o = slice_q;
  assign sample_valid_o = valid_q;
  assign sample_slice_o = sslice_q;
  assign sample_dist_o = dist_q;
  assign timeout_o = timeout_q;
endmodule

// File: tb/tb_slice_scan_scheduler.sv
// tb_slice_scan_scheduler: randomized scans checked against an event-timing model of the scheduler
module tb_slice_scan_scheduler;
  localparam int NS = 3, ST = 4, MT = 20;
  logic clk = 0, rst = 1, start_i = 0, pause_i = 0, meas_done_i = 0, step_ack_i = 0;
  logic [31:0] distance_i = 0;
  logic meas_trig_o, step_req_o, finish_o, sample_valid_o, timeout_o;
  logic [1:0] state_o;
  logic [4:0] slice_num_o, sample_slice_o;
  logic [15:0] sample_dist_o;
  int cyc = 0, n_vec = 0, n_bad = 0;

  slice_scan_scheduler #(.NUM_SLICES(NS), .SETTLE_CYCLES(ST), .MEAS_TIMEOUT(MT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .pause_i(pause_i),
    .meas_trig_o(meas_trig_o), .meas_done_i(meas_done_i), .distance_i(distance_i),
    .step_req_o(step_req_o), .step_ack_i(step_ack_i), .state_o(state_o),
    .slice_num_o(slice_num_o), .finish_o(finish_o), .sample_valid_o(sample_valid_o),
    .sample_slice_o(sample_slice_o), .sample_dist_o(sample_dist_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [32:0] outs();
    return {meas_trig_o, step_req_o, state_o, slice_num_o, finish_o, sample_valid_o,
            sample_slice_o, sample_dist_o, timeout_o};
  endfunction

  // Each cycle: observe outputs, compare with the predicted event times, then drive this cycle's inputs.
  task automatic run_scan(input int silent, input int pslice, input bit dbl, input bit sp, input bit abort);
    int exp_trig, exp_samp = -1, done_at = -1, ack_at = -1, p_at = -1, p2_at = -1;
    int stray_at = -1, paused_at = -1, resume_at = -1;
    int sl = 0, steps = 0, pauses = 0, exp_pauses = 0;
    bit exp_to = 0, pend = 0, fin = 0, prev_req = 0;
    logic [1:0] prev_st = 0;
    logic [31:0] dv = 0;
    logic [15:0] exp_d = 0;
    start_i = 1;
    pause_i = sp;
    exp_trig = cyc + ST + 1;
    tick();
    start_i = 0;
    pause_i = 0;
    chk("start_state", state_o, 1);
    chk("start_slices", slice_num_o, 0);
    chk("start_timeout", timeout_o, 0);
    chk("start_finish", finish_o, 0);
    for (int n = 0; n < 2000 && !fin; n++) begin
      meas_done_i = 0;
      step_ack_i = 0;
      pause_i = 0;
      distance_i = $urandom;
      if (abort && step_req_o) begin
        rst = 1;
        tick();
        rst = 0;
        chk("rst_outs", outs(), 0);
        step_ack_i = 1;
        tick();
        step_ack_i = 0;
        chk("stray_ack_state", state_o, 0);
        chk("stray_ack_req", step_req_o, 0);
        return;
      end
      if (state_o == 2 && prev_st != 2) pauses++;
      prev_st = state_o;
      if (meas_trig_o) begin
        chk("trig_cycle", cyc, exp_trig);
        exp_trig = -1;
        stray_at = cyc + 1;
        if (silent[sl]) begin
          exp_samp = cyc + 1 + MT;
          exp_d = 16'hFFFF;
          exp_to = 1;
          done_at = -1;
        end else begin
          done_at = cyc + int'($urandom_range(1, MT));
          exp_samp = done_at + 1;
          dv = $urandom;
          exp_d = dv[15:0];
        end
        if (sl == pslice) begin
          p_at = cyc + 1;
          pend = 1;
        end
      end
      if (cyc == done_at) begin
        meas_done_i = 1;
        distance_i = dv;
      end
      if (cyc == p_at || cyc == p2_at) pause_i = 1;
      if (cyc == stray_at) step_ack_i = 1;
      if (step_req_o && !prev_req) begin
        steps++;
        chk("step_with_sample", sample_valid_o, 1);
        ack_at = cyc + int'($urandom_range(1, 5));
      end
      prev_req = step_req_o;
      if (sample_valid_o) begin
        chk("samp_cycle", cyc, exp_samp);
        chk("samp_slice", sample_slice_o, sl);
        chk("samp_dist", sample_dist_o, exp_d);
        chk("samp_timeout", timeout_o, exp_to);
        sl++;
        chk("slice_count", slice_num_o, sl);
        if (sl == NS) begin
          fin = 1;
          chk("done_state", state_o, 3);
          chk("done_finish", finish_o, 1);
          chk("done_no_step", step_req_o, 0);
          chk("step_episodes", steps, NS - 1);
          chk("pause_entries", pauses, exp_pauses);
        end
      end
      if (cyc == ack_at) begin
        step_ack_i = 1;
        meas_done_i = 1;
        if (pend) begin
          paused_at = cyc + ST + 1;
          exp_pauses++;
          pend = 0;
        end else exp_trig = cyc + ST + 1;
        if (dbl && sl == 1) begin
          p_at = cyc + 1;
          p2_at = cyc + 1 + int'($urandom_range(1, ST - 1));
        end
      end
      if (cyc == paused_at) begin
        chk("paused_state", state_o, 2);
        resume_at = cyc + int'($urandom_range(1, 6));
      end
      if (cyc == resume_at) begin
        pause_i = 1;
        exp_trig = cyc + ST + 1;
      end
      tick();
    end
    meas_done_i = 0;
    step_ack_i = 0;
    pause_i = 0;
    if (!fin) chk("scan_cycle_budget", 0, 1);
    else begin
      repeat (3) tick();
      chk("done_hold_slices", slice_num_o, NS);
      chk("done_hold_state", state_o, 3);
    end
  endtask

  initial begin
    tick();
    tick();
    chk("reset_outs", outs(), 0);
    rst = 0;
    tick();
    run_scan(0, -1, 0, 0, 0);
    run_scan(2, -1, 0, 0, 0);
    run_scan(0, 0, 0, 0, 0);
    run_scan(0, -1, 1, 0, 0);
    run_scan(0, -1, 0, 0, 1);
    run_scan(0, -1, 0, 1, 0);
    for (int i = 0; i < 8; i++)
      run_scan(int'($urandom_range(0, 7)), int'($urandom_range(0, NS)) - 1, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
